// File: rtl/word_adder_seq_pkg.sv
// rtl/word_adder_seq_pkg.sv - shared state encoding and sizing helpers for word_adder_seq
package word_adder_seq_pkg;

  localparam int DEFAULT_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte-index width; never narrower than one bit, even for a single-byte word.
  function automatic int lane_w(input int wb);
    return (wb <= 2) ? 1 : $clog2(wb);
  endfunction

endpackage

// File: rtl/eightBit_rippleCarryAdder.sv
// rtl/eightBit_rippleCarryAdder.sv - 8-bit ripple-carry adder built from a full-adder chain
module eightBit_rippleCarryAdder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

// File: rtl/word_adder_seq.sv
// rtl/word_adder_seq.sv - byte-serial modulo-2^N adder with an internal accumulator
// for chained multi-operand sums; one byte lane per cycle through a shared 8-bit adder.
module word_adder_seq
  import word_adder_seq_pkg::*;
#(
  parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] a,
  input  logic [8*WORD_BYTES-1:0] b,
  input  logic                    cin,
  input  logic                    acc_mode,
  input  logic                    clr_acc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] sum,
  output logic                    cout
);

  localparam int N  = 8 * WORD_BYTES;
  localparam int LW = lane_w(WORD_BYTES);

  state_t          state;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [N-1:0]    acc;
  logic [LW-1:0]   idx;
  logic            carry;

  logic [7:0]      lane_a;
  logic [7:0]      lane_b;
  logic [7:0]      lane_sum;
  logic            lane_cout;
  logic            last_lane;

  assign lane_a    = op_a[8*idx +: 8];
  assign lane_b    = op_b[8*idx +: 8];
  assign last_lane = (idx == LW'(WORD_BYTES - 1));

  eightBit_rippleCarryAdder u_rca (
    .a    (lane_a),
    .b    (lane_b),
    .cin  (carry),
    .sum  (lane_sum),
    .cout (lane_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_acc) acc <= '0;
          if (in_valid && in_ready) begin
            // A clear arriving with an accumulate request wins: the operation sees zero.
            op_a     <= acc_mode ? (clr_acc ? '0 : acc) : a;
            op_b     <= b;
            carry    <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[8*idx +: 8] <= lane_sum;
          carry           <= lane_cout;
          idx             <= idx + LW'(1);
          if (last_lane) begin
            cout      <= lane_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc       <= sum;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
